// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake, operands and results of the sequential divider.
interface seq_divider_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   next_r;
    logic [WIDTH-1:0] next_q;

    // A negative trial difference means the divisor did not fit: restore the shifted remainder.
    always_comb begin
        shifted = {r[WIDTH-1:0], q[WIDTH-1]};
        diff    = shifted - {1'b0, d};
        next_r  = diff[WIDTH] ? shifted : diff;
        next_q  = {q[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (!bus.start) begin
                        state <= IDLE;
                    end else if (bus.divisor == '0) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= '1;
                        remainder   <= bus.dividend;
                        div_by_zero <= 1'b1;
                    end else begin
                        state <= RUN;
                        busy  <= 1'b1;
                        q     <= bus.dividend;
                        d     <= bus.divisor;
                        r     <= '0;
                        cnt   <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    r   <= next_r;
                    q   <= next_q;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= next_q;
                        remainder   <= next_r[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
endmodule
